// File: rtl/cpu_pipe_ctrl_if.sv
// Hazard requests in, per-stage pipeline register controls out.
// The slave side is the pipeline control unit.
interface cpu_pipe_ctrl_if;
    logic        BUBBLE_DATA_I;
    logic        BRANCH_MISS_I;
    logic        RET_D_I;
    logic        EXC_M_I;
    logic        HALT_W_I;
    logic        F_STALL_O;
    logic        D_STALL_O;
    logic        D_BUBBLE_O;
    logic        E_BUBBLE_O;
    logic        M_BUBBLE_O;
    logic        W_STALL_O;
    logic        HALTED_O;
    logic [15:0] STALL_CNT_O;
    logic [15:0] FLUSH_CNT_O;

    modport master (
        output BUBBLE_DATA_I, BRANCH_MISS_I, RET_D_I, EXC_M_I, HALT_W_I,
        input  F_STALL_O, D_STALL_O, D_BUBBLE_O, E_BUBBLE_O,
        input  M_BUBBLE_O, W_STALL_O, HALTED_O, STALL_CNT_O, FLUSH_CNT_O
    );

    modport slave (
        input  BUBBLE_DATA_I, BRANCH_MISS_I, RET_D_I, EXC_M_I, HALT_W_I,
        output F_STALL_O, D_STALL_O, D_BUBBLE_O, E_BUBBLE_O,
        output M_BUBBLE_O, W_STALL_O, HALTED_O, STALL_CNT_O, FLUSH_CNT_O
    );
endinterface

// File: rtl/cpu_pipe_ctrl.sv
// Pipeline control for the five-stage PIPE core: hazard priority,
// ret-wait / halt state machine and saturating stall/flush counters.
module cpu_pipe_ctrl (
    input  logic CLK_I,
    input  logic RST_N_I,
    cpu_pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, RET_WAIT, HALT} state_t;

    state_t      state;
    logic [1:0]  ret_cnt;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        halting;
    logic        f_stall;
    logic        d_stall;
    logic        d_bubble;
    logic        e_bubble;
    logic        m_bubble;
    logic        w_stall;

    assign halting = (state == HALT) || bus.HALT_W_I;

    // Per-stage controls from state and hazards, highest priority first.
    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        w_stall  = 1'b0;
        if (halting) begin
            f_stall  = 1'b1;
            d_stall  = 1'b1;
            w_stall  = 1'b1;
            m_bubble = 1'b1;
        end else begin
            if (bus.BRANCH_MISS_I) begin
                d_bubble = 1'b1;
                e_bubble = 1'b1;
            end else if (bus.BUBBLE_DATA_I) begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_bubble = 1'b1;
            end else if (state == RET_WAIT || bus.RET_D_I) begin
                f_stall  = 1'b1;
                d_bubble = 1'b1;
            end
            // Keep the excepting instruction's successor out of memory/CC.
            if (bus.EXC_M_I) begin
                m_bubble = 1'b1;
            end
        end
    end

    assign bus.F_STALL_O   = f_stall;
    assign bus.D_STALL_O   = d_stall;
    assign bus.D_BUBBLE_O  = d_bubble;
    assign bus.E_BUBBLE_O  = e_bubble;
    assign bus.M_BUBBLE_O  = m_bubble;
    assign bus.W_STALL_O   = w_stall;
    assign bus.HALTED_O    = (state == HALT);
    assign bus.STALL_CNT_O = stall_cnt;
    assign bus.FLUSH_CNT_O = flush_cnt;

    // Ret-wait / halt state machine; load/use freezes state and ret count.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state   <= RUN;
            ret_cnt <= 2'd0;
        end else if (halting) begin
            state   <= HALT;
            ret_cnt <= 2'd0;
        end else if (bus.BRANCH_MISS_I) begin
            state   <= RUN;
            ret_cnt <= 2'd0;
        end else if (!bus.BUBBLE_DATA_I) begin
            case (state)
                RUN: begin
                    if (bus.RET_D_I) begin
                        state   <= RET_WAIT;
                        ret_cnt <= 2'd2;
                    end
                end
                RET_WAIT: begin
                    ret_cnt <= ret_cnt - 2'd1;
                    if (ret_cnt == 2'd1) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state   <= RUN;
                    ret_cnt <= 2'd0;
                end
            endcase
        end
    end

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (f_stall && state != HALT && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (!halting && bus.BRANCH_MISS_I && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_cpu_pipe_ctrl.sv
// Directed bench for cpu_pipe_ctrl: inputs change on the falling edge,
// controls are sampled 1 ns later, state lands on the rising edge.
module tb_cpu_pipe_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    logic [5:0] ctl;

    cpu_pipe_ctrl_if bus ();

    cpu_pipe_ctrl dut (
        .CLK_I   (clk),
        .RST_N_I (rst_n),
        .bus     (bus)
    );

    // Order: F_STALL D_STALL D_BUBBLE E_BUBBLE M_BUBBLE W_STALL
    assign ctl = {bus.F_STALL_O, bus.D_STALL_O, bus.D_BUBBLE_O,
                  bus.E_BUBBLE_O, bus.M_BUBBLE_O, bus.W_STALL_O};

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_RET  = 6'b101000;
    localparam logic [5:0] C_MISS = 6'b001100;
    localparam logic [5:0] C_HALT = 6'b110011;
    localparam logic [5:0] C_EXC  = 6'b000010;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.BUBBLE_DATA_I = 1'b0;
        bus.BRANCH_MISS_I = 1'b0;
        bus.RET_D_I       = 1'b0;
        bus.EXC_M_I       = 1'b0;
        bus.HALT_W_I      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++;
        if (ctl !== C_NONE) begin
            $display("FAIL reset_ctl got %b want %b", ctl, C_NONE);
            n_fail++;
        end
        n_chk++;
        if (bus.HALTED_O !== 1'b0) begin
            $display("FAIL reset_halted got %b want 0", bus.HALTED_O);
            n_fail++;
        end
        n_chk++;
        if (bus.STALL_CNT_O !== 16'd0 || bus.FLUSH_CNT_O !== 16'd0) begin
            $display("FAIL reset_cnt got %h/%h want 0/0",
                     bus.STALL_CNT_O, bus.FLUSH_CNT_O);
            n_fail++;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.BUBBLE_DATA_I = 1'b1;
        #1;
        n_chk++;
        if (ctl !== C_LU) begin
            $display("FAIL lu_ctl got %b want %b", ctl, C_LU);
            n_fail++;
        end
        @(negedge clk);
        bus.BUBBLE_DATA_I = 1'b0;
        #1;
        n_chk++;
        if (ctl !== C_NONE) begin
            $display("FAIL lu_after got %b want %b", ctl, C_NONE);
            n_fail++;
        end
        n_chk++;
        if (bus.STALL_CNT_O !== 16'd1) begin
            $display("FAIL lu_cnt got %0d want 1", bus.STALL_CNT_O);
            n_fail++;
        end
    endtask

    task automatic test_ret();
        do_reset();
        bus.RET_D_I = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++;
            if (ctl !== C_RET) begin
                $display("FAIL ret_cyc%0d got %b want %b", i, ctl, C_RET);
                n_fail++;
            end
            @(negedge clk);
            bus.RET_D_I = 1'b0;
        end
        #1;
        n_chk++;
        if (ctl !== C_NONE) begin
            $display("FAIL ret_end got %b want %b", ctl, C_NONE);
            n_fail++;
        end
        n_chk++;
        if (bus.STALL_CNT_O !== 16'd3) begin
            $display("FAIL ret_cnt got %0d want 3", bus.STALL_CNT_O);
            n_fail++;
        end
    endtask

    task automatic test_ret_blocked();
        logic [5:0] exp_seq [0:5];
        exp_seq[0] = C_LU;
        exp_seq[1] = C_LU;
        exp_seq[2] = C_RET;
        exp_seq[3] = C_RET;
        exp_seq[4] = C_RET;
        exp_seq[5] = C_NONE;
        do_reset();
        bus.RET_D_I       = 1'b1;
        bus.BUBBLE_DATA_I = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_chk++;
            if (ctl !== exp_seq[i]) begin
                $display("FAIL retblk_cyc%0d got %b want %b",
                         i, ctl, exp_seq[i]);
                n_fail++;
            end
            @(negedge clk);
            if (i == 1) bus.BUBBLE_DATA_I = 1'b0;
            if (i == 2) bus.RET_D_I = 1'b0;
        end
        n_chk++;
        if (bus.STALL_CNT_O !== 16'd5) begin
            $display("FAIL retblk_cnt got %0d want 5", bus.STALL_CNT_O);
            n_fail++;
        end
    endtask

    task automatic test_miss_in_ret();
        do_reset();
        bus.RET_D_I = 1'b1;
        @(negedge clk);
        bus.RET_D_I       = 1'b0;
        bus.BRANCH_MISS_I = 1'b1;
        #1;
        n_chk++;
        if (ctl !== C_MISS) begin
            $display("FAIL miss_ctl got %b want %b", ctl, C_MISS);
            n_fail++;
        end
        @(negedge clk);
        bus.BRANCH_MISS_I = 1'b0;
        #1;
        n_chk++;
        if (ctl !== C_NONE) begin
            $display("FAIL miss_after got %b want %b", ctl, C_NONE);
            n_fail++;
        end
        n_chk++;
        if (bus.FLUSH_CNT_O !== 16'd1 || bus.STALL_CNT_O !== 16'd1) begin
            $display("FAIL miss_cnt got %0d/%0d want 1/1",
                     bus.FLUSH_CNT_O, bus.STALL_CNT_O);
            n_fail++;
        end
    endtask

    task automatic test_exception();
        do_reset();
        bus.EXC_M_I = 1'b1;
        #1;
        n_chk++;
        if (ctl !== C_EXC) begin
            $display("FAIL exc_ctl got %b want %b", ctl, C_EXC);
            n_fail++;
        end
        bus.BUBBLE_DATA_I = 1'b1;
        #1;
        n_chk++;
        if (ctl !== (C_LU | C_EXC)) begin
            $display("FAIL exc_lu got %b want %b", ctl, C_LU | C_EXC);
            n_fail++;
        end
        bus.BUBBLE_DATA_I = 1'b0;
        bus.BRANCH_MISS_I = 1'b1;
        #1;
        n_chk++;
        if (ctl !== (C_MISS | C_EXC)) begin
            $display("FAIL exc_miss got %b want %b", ctl, C_MISS | C_EXC);
            n_fail++;
        end
        bus.BRANCH_MISS_I = 1'b0;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        bus.HALT_W_I      = 1'b1;
        bus.BRANCH_MISS_I = 1'b1;
        #1;
        n_chk++;
        if (ctl !== C_HALT || bus.HALTED_O !== 1'b0) begin
            $display("FAIL halt_entry got %b/%b want %b/0",
                     ctl, bus.HALTED_O, C_HALT);
            n_fail++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_chk++;
        if (bus.HALTED_O !== 1'b1 || ctl !== C_HALT) begin
            $display("FAIL halt_state got %b/%b want 1/%b",
                     bus.HALTED_O, ctl, C_HALT);
            n_fail++;
        end
        n_chk++;
        if (bus.FLUSH_CNT_O !== 16'd0) begin
            $display("FAIL halt_flush got %0d want 0", bus.FLUSH_CNT_O);
            n_fail++;
        end
        bus.RET_D_I = 1'b1;
        repeat (3) @(negedge clk);
        bus.RET_D_I = 1'b0;
        #1;
        n_chk++;
        if (bus.HALTED_O !== 1'b1 || bus.STALL_CNT_O !== 16'd1) begin
            $display("FAIL halt_hold got %b/%0d want 1/1",
                     bus.HALTED_O, bus.STALL_CNT_O);
            n_fail++;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.HALTED_O !== 1'b0 || ctl !== C_NONE) begin
            $display("FAIL halt_async_rst got %b/%b want 0/%b",
                     bus.HALTED_O, ctl, C_NONE);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        bus.BUBBLE_DATA_I = 1'b1;
        repeat (70000) @(negedge clk);
        #1;
        n_chk++;
        if (bus.STALL_CNT_O !== 16'hFFFF) begin
            $display("FAIL sat_cnt got %h want FFFF", bus.STALL_CNT_O);
            n_fail++;
        end
        repeat (5) @(negedge clk);
        bus.BUBBLE_DATA_I = 1'b0;
        #1;
        n_chk++;
        if (bus.STALL_CNT_O !== 16'hFFFF || ctl !== C_NONE) begin
            $display("FAIL sat_hold got %h/%b want FFFF/%b",
                     bus.STALL_CNT_O, ctl, C_NONE);
            n_fail++;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_ret();
        test_ret_blocked();
        test_miss_in_ret();
        test_exception();
        test_halt();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
